// File: rtl/dma_p0_packer.sv
// Write-back packer: gathers FP16 results into 128-bit words, queues them in a
// small FIFO and issues addressed write beats to memory-controller port 0.
module dma_p0_packer #(
    parameter int LANES      = 8,
    parameter int ADDR_W     = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  in_we,
    input  logic [15:0]           in_data,
    input  logic                  in_last,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [16*LANES-1:0]   mem_data,
    output logic [2*LANES-1:0]    mem_mask,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           words_written,
    output logic                  overflow
);

    localparam int DATA_W  = 16 * LANES;
    localparam int MASK_W  = 2 * LANES;
    localparam int LANE_W  = $clog2(LANES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WADDR_W = ADDR_W - 4;

    localparam logic [LANE_W-1:0]  LANE_ONE  = LANE_W'(1'b1);
    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [WADDR_W-1:0] WADDR_ONE = WADDR_W'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PACK  = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Byte enables for the first lanes_used lanes of a word.
    function automatic logic [MASK_W-1:0] lane_mask(input logic [LANE_W-1:0] lanes_used);
        logic [MASK_W-1:0] m;
        m = {MASK_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(lanes_used)) begin
                m[2*i +: 2] = 2'b11;
            end else begin
                m[2*i +: 2] = 2'b00;
            end
        end
        return m;
    endfunction

    // Widen a byte-enable mask to a bit mask over the data word.
    function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] d;
        d = {DATA_W{1'b0}};
        for (int i = 0; i < MASK_W; i++) begin
            d[8*i +: 8] = {8{m[i]}};
        end
        return d;
    endfunction

    state_t              state_r, state_next_s;
    logic [LANE_W-1:0]   lane_cnt_r, lane_next_s;
    logic [DATA_W-1:0]   stage_r, stage_next_s, stage_wr_s;
    logic                push_req_s, push_ok_s, drop_s, load_start_s;
    logic [DATA_W-1:0]   push_data_s;
    logic [MASK_W-1:0]   push_mask_s;

    logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [MASK_W-1:0]   fifo_mask_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r, head_idx_s;
    logic [CNT_W-1:0]    count_r;
    logic                accept_s, empty_after_pop_s, head_load_s, head_avail_s;

    logic                mem_valid_r;
    logic [DATA_W-1:0]   mem_data_r;
    logic [MASK_W-1:0]   mem_mask_r;
    logic [WADDR_W-1:0]  waddr_r;
    logic [15:0]         words_written_r;
    logic                overflow_r, busy_r, done_r;
    logic                base_low_unused_s;

    assign base_low_unused_s = ^base_addr[3:0];

    assign accept_s          = mem_valid_r & mem_ready;
    assign push_ok_s         = push_req_s & ((count_r != CNT_FULL) | accept_s);
    assign drop_s            = push_req_s & ~push_ok_s;
    assign empty_after_pop_s = (count_r == CNT_ZERO) | ((count_r == CNT_ONE) & accept_s);
    // The head entry stays in the FIFO until accepted, so on accept the next one is shown.
    assign head_load_s       = ~mem_valid_r | accept_s;
    assign head_avail_s      = accept_s ? (count_r > CNT_ONE) : (count_r != CNT_ZERO);
    assign head_idx_s        = accept_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

    assign mem_valid     = mem_valid_r;
    assign mem_addr      = {waddr_r, 4'b0000};
    assign mem_data      = mem_data_r;
    assign mem_mask      = mem_mask_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_written = words_written_r;
    assign overflow      = overflow_r;

    // Staging word with the incoming half written into the current lane.
    always_comb begin
        stage_wr_s = stage_r;
        stage_wr_s[{lane_cnt_r, 4'b0000} +: 16] = in_data;
    end

    // Next-state, lane packing and FIFO push requests.
    always_comb begin
        state_next_s = state_r;
        lane_next_s  = lane_cnt_r;
        stage_next_s = stage_r;
        push_req_s   = 1'b0;
        push_data_s  = {DATA_W{1'b0}};
        push_mask_s  = {MASK_W{1'b0}};
        load_start_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load_start_s = 1'b1;
                    lane_next_s  = {LANE_W{1'b0}};
                    stage_next_s = {DATA_W{1'b0}};
                    state_next_s = S_PACK;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PACK: begin
                if (in_we) begin
                    if (lane_cnt_r == LANE_LAST) begin
                        push_req_s   = 1'b1;
                        push_data_s  = stage_wr_s;
                        push_mask_s  = {MASK_W{1'b1}};
                        stage_next_s = {DATA_W{1'b0}};
                        lane_next_s  = {LANE_W{1'b0}};
                    end else begin
                        stage_next_s = stage_wr_s;
                        lane_next_s  = lane_cnt_r + LANE_ONE;
                    end
                end else begin
                    stage_next_s = stage_r;
                end
                if (in_last) begin
                    state_next_s = S_FLUSH;
                end else begin
                    state_next_s = S_PACK;
                end
            end
            S_FLUSH: begin
                stage_next_s = {DATA_W{1'b0}};
                lane_next_s  = {LANE_W{1'b0}};
                if (lane_cnt_r != {LANE_W{1'b0}}) begin
                    push_req_s   = 1'b1;
                    push_mask_s  = lane_mask(lane_cnt_r);
                    push_data_s  = stage_r & expand_mask(lane_mask(lane_cnt_r));
                    state_next_s = S_DRAIN;
                end else if (empty_after_pop_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty_after_pop_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register, staging word and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            lane_cnt_r <= {LANE_W{1'b0}};
            stage_r    <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            lane_cnt_r <= lane_next_s;
            stage_r    <= stage_next_s;
            busy_r     <= (state_next_s == S_PACK) || (state_next_s == S_FLUSH) ||
                          (state_next_s == S_DRAIN);
            done_r     <= (state_next_s == S_DONE);
        end
    end

    // FIFO storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_data_r[wr_ptr_r] <= push_data_s;
            fifo_mask_r[wr_ptr_r] <= push_mask_s;
        end
    end

    // FIFO pointers, occupancy and registered output head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            mem_valid_r <= 1'b0;
            mem_data_r  <= {DATA_W{1'b0}};
            mem_mask_r  <= {MASK_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (accept_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, accept_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (head_load_s) begin
                mem_valid_r <= head_avail_s;
                if (head_avail_s) begin
                    mem_data_r <= fifo_data_r[head_idx_s];
                    mem_mask_r <= fifo_mask_r[head_idx_s];
                end
            end
        end
    end

    // Beat address, accepted-beat count and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_r         <= {WADDR_W{1'b0}};
            words_written_r <= 16'h0000;
            overflow_r      <= 1'b0;
        end else if (load_start_s) begin
            waddr_r         <= base_addr[ADDR_W-1:4];
            words_written_r <= 16'h0000;
            overflow_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                waddr_r <= waddr_r + WADDR_ONE;
                if (words_written_r != 16'hFFFF) begin
                    words_written_r <= words_written_r + 16'h0001;
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_p0_packer.sv
// Scoreboard bench for dma_p0_packer: stimulus pushes expected beats into a
// queue, an independent monitor pops and compares each accepted beat.
module tb_dma_p0_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [29:0]   base_addr;
    logic          in_we;
    logic [15:0]   in_data;
    logic          in_last;
    logic          mem_valid;
    logic [29:0]   mem_addr;
    logic [127:0]  mem_data;
    logic [15:0]   mem_mask;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic [15:0]   words_written;
    logic          overflow;

    dma_p0_packer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_we(in_we), .in_data(in_data), .in_last(in_last),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_mask(mem_mask), .mem_ready(mem_ready), .busy(busy), .done(done),
        .words_written(words_written), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } beat_t;

    beat_t        exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           last_accept_cyc = -1;

    logic [127:0] m_word;
    int           m_lane;
    logic [29:0]  m_addr;
    int           stall_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted beat and hold-stability under backpressure.
    initial begin
        beat_t e;
        beat_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", mem_valid, 1'b1);
                    check("hold_addr", mem_addr, prev.addr);
                    check("hold_data", mem_data, prev.data);
                end
                prev_stall = mem_valid && !mem_ready;
                prev.addr = mem_addr;
                prev.data = mem_data;
                prev.mask = mem_mask;
                if (mem_valid && mem_ready) begin
                    last_accept_cyc = cyc + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual_addr=%0h required=none", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", mem_addr, e.addr);
                        check("beat_data", mem_data, e.data);
                        check("beat_mask", mem_mask, e.mask);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [15:0] mask);
        beat_t b;
        if (!mem_ready && stall_cnt >= 4) begin
            m_word = '0;
        end else begin
            if (!mem_ready) stall_cnt++;
            b.addr = m_addr;
            b.data = m_word;
            b.mask = mask;
            exp_q.push_back(b);
            m_addr = m_addr + 30'h10;
        end
        m_word = '0;
        m_lane = 0;
    endtask

    task automatic model_flush();
        logic [31:0] mk;
        if (m_lane != 0) begin
            mk = (32'h1 << (2 * m_lane)) - 32'h1;
            model_push(mk[15:0]);
        end
    endtask

    task automatic do_start(input logic [29:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_addr = {b[29:4], 4'h0};
        m_word = '0;
        m_lane = 0;
        stall_cnt = 0;
    endtask

    task automatic send_half(input logic [15:0] d, input logic last);
        in_we = 1'b1;
        in_data = d;
        in_last = last;
        m_word[m_lane*16 +: 16] = d;
        m_lane++;
        if (m_lane == 8) model_push(16'hFFFF);
        if (last) model_flush();
        tick();
        in_we = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_last();
        in_last = 1'b1;
        model_flush();
        tick();
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 80) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout actual=no_done required=done", name);
        end else begin
            check({name, "_done_after_accept"}, last_accept_cyc, cyc);
            check({name, "_busy_at_done"}, busy, 1'b0);
            check({name, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_valid"}, mem_valid, 1'b0);
        check({name, "_addr"}, mem_addr, 30'h0);
        check({name, "_data"}, mem_data, 128'h0);
        check({name, "_mask"}, mem_mask, 16'h0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_ww"}, words_written, 16'h0);
        check({name, "_ovf"}, overflow, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        base_addr = 30'h0;
        in_we = 1'b0;
        in_data = 16'h0;
        in_last = 1'b0;
        mem_ready = 1'b1;
        m_word = '0;
        m_lane = 0;
        m_addr = 30'h0;
        stall_cnt = 0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b1;
        tick();

        // Full words
        do_start(30'h100);
        check("start_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) send_half(16'h3C00 + 16'(i), 1'b0);
        send_last();
        wait_done("full");
        check("full_ww", words_written, 16'd2);
        tick();

        // Partial flush, low address bits ignored
        do_start(30'h20B);
        for (int i = 0; i < 11; i++) send_half(16'h4000 + 16'(i), 1'b0);
        send_last();
        wait_done("partial");
        check("partial_ww", words_written, 16'd2);
        tick();

        // Eighth half together with the end-of-op pulse
        do_start(30'h300);
        for (int i = 0; i < 7; i++) send_half(16'h5000 + 16'(i), 1'b0);
        send_half(16'h5007, 1'b1);
        wait_done("simul");
        check("simul_ww", words_written, 16'd1);
        tick();

        // Backpressure and overflow
        mem_ready = 1'b0;
        do_start(30'h100);
        for (int i = 0; i < 32; i++) send_half(16'h6000 + 16'(i), 1'b0);
        check("bp_no_ovf_4", overflow, 1'b0);
        for (int i = 32; i < 40; i++) send_half(16'h6000 + 16'(i), 1'b0);
        check("bp_ovf_5", overflow, 1'b1);
        for (int i = 40; i < 48; i++) send_half(16'h6000 + 16'(i), 1'b0);
        check("bp_head_valid", mem_valid, 1'b1);
        check("bp_head_addr", mem_addr, 30'h100);
        check("bp_ww_stalled", words_written, 16'd0);
        send_last();
        mem_ready = 1'b1;
        wait_done("bp");
        check("bp_ww", words_written, 16'd4);
        check("bp_ovf_sticky", overflow, 1'b1);
        tick();

        // Reset with words queued
        mem_ready = 1'b0;
        do_start(30'h200);
        for (int i = 0; i < 24; i++) send_half(16'h7000 + 16'(i), 1'b0);
        check("rst_pre_valid", mem_valid, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        tick();
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        do_start(30'h340);
        for (int i = 0; i < 8; i++) send_half(16'h7100 + 16'(i), 1'b0);
        send_last();
        wait_done("after_rst");
        check("after_rst_ww", words_written, 16'd1);
        tick();

        // Start while busy is ignored
        do_start(30'h500);
        for (int i = 0; i < 4; i++) send_half(16'h8000 + 16'(i), 1'b0);
        base_addr = 30'h900;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 4; i < 16; i++) send_half(16'h8000 + 16'(i), 1'b0);
        send_last();
        wait_done("busy_start");
        check("busy_start_ww", words_written, 16'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
